// File: rtl/ycbcr_pkg.sv
// ---------------------------------------------------------------------------
// ycbcr_pkg
//  Shared definitions for the YCbCr 4:4:4 -> 4:2:2 packer:
//    - pair_state_t : pixel-pair FSM encoding (ST_EVEN, ST_ODD, ST_EMIT1)
//    - SYNC_DLY     : clocks of delay applied to vsync/href
//    - PIX_W/WORD_W : component and packed-word widths
//    - pack_word()  : builds a {C,Y} 4:2:2 word
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package ycbcr_pkg;

    localparam int PIX_W    = 8;
    localparam int WORD_W   = 16;
    localparam int SYNC_DLY = 2;

    typedef enum logic [1:0] {
        ST_EVEN  = 2'd0,   // waiting for the first pixel of a pair
        ST_ODD   = 2'd1,   // first pixel held, waiting for its partner
        ST_EMIT1 = 2'd2    // second word of the pair goes out this cycle
    } pair_state_t;

    function automatic logic [WORD_W-1:0] pack_word(input logic [PIX_W-1:0] c,
                                                    input logic [PIX_W-1:0] y);
        return {c, y};
    endfunction

endpackage

// File: rtl/chroma_avg2.sv
// ---------------------------------------------------------------------------
// chroma_avg2
//  Combinational two-input average with round-half-up: avg = (a + b + 1) >> 1.
//  Ports:
//    a   in  8  first chroma sample
//    b   in  8  second chroma sample
//    avg out 8  rounded mean
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module chroma_avg2
    import ycbcr_pkg::*;
(
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    output logic [PIX_W-1:0] avg
);

    // (a+b+1)>>1 rewritten as (a>>1)+(b>>1)+(a[0]|b[0]): the rounding carry
    // exists exactly when at least one LSB is set, and the result never
    // exceeds 255, so the whole computation stays 8 bits wide.
    assign avg = {1'b0, a[PIX_W-1:1]} + {1'b0, b[PIX_W-1:1]}
               + {{(PIX_W-1){1'b0}}, a[0] | b[0]};

endmodule

// File: rtl/image_ycbcr444_ycbcr422.sv
// ---------------------------------------------------------------------------
// image_ycbcr444_ycbcr422
//  Packs a YCbCr 4:4:4 pixel stream into 16-bit 4:2:2 words {C,Y}. Chroma is
//  shared per horizontal pixel pair: the first word carries one chroma
//  component with Y0, the second the other component with Y1. A line with an
//  odd pixel count ends with a single word built from the lone pixel.
//
//  Build option: define CHROMA_AVG_EN to average the pair's chroma
//  (round-half-up); otherwise the first pixel's chroma is used (decimation).
//  Latency and handshake are identical in both builds.
//
//  Parameter:
//    CB_FIRST  1: first word carries Cb, second Cr; 0: Cr first.
//  Ports:
//    clk               in   1   pixel clock
//    rst_n             in   1   asynchronous reset, active low
//    per_frame_vsync   in   1   input vsync
//    per_frame_href    in   1   input line-valid
//    per_frame_clken   in   1   input pixel strobe (pixel taken on href&clken)
//    per_img_Y         in   8   input luma
//    per_img_Cb        in   8   input blue chroma
//    per_img_Cr        in   8   input red chroma
//    post_frame_vsync  out  1   vsync delayed 2 clk
//    post_frame_href   out  1   href delayed 2 clk
//    post_frame_clken  out  1   one-clk strobe per output word
//    post_img_YCbCr    out  16  {C,Y} word, held between strobes
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module image_ycbcr444_ycbcr422
    import ycbcr_pkg::*;
#(
    parameter bit CB_FIRST = 1'b1
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [PIX_W-1:0]  per_img_Y,
    input  logic [PIX_W-1:0]  per_img_Cb,
    input  logic [PIX_W-1:0]  per_img_Cr,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
    output logic [WORD_W-1:0] post_img_YCbCr
);

    pair_state_t state, state_nxt;

    logic [PIX_W-1:0]    y0_q, cb0_q, cr0_q;   // first pixel of the pair
    logic [PIX_W-1:0]    y1_q, c1_q;           // second word, ready for ST_EMIT1
    logic [SYNC_DLY-1:0] vsync_dly, href_dly;
    logic [WORD_W-1:0]   word_q, word_nxt;
    logic                clken_q;

    logic                accept;
    logic                load_p0, load_pair, emit;
    logic [PIX_W-1:0]    cb_pair, cr_pair;
    logic [PIX_W-1:0]    c0_pair, c1_pair, c0_single;

    assign accept = per_frame_href & per_frame_clken;

    // Pair chroma is formed from the held first pixel and the live second
    // pixel, so word0 can be registered in the same cycle p1 is accepted.
`ifdef CHROMA_AVG_EN
    chroma_avg2 u_avg_cb (.a(cb0_q), .b(per_img_Cb), .avg(cb_pair));
    chroma_avg2 u_avg_cr (.a(cr0_q), .b(per_img_Cr), .avg(cr_pair));
`else
    assign cb_pair = cb0_q;
    assign cr_pair = cr0_q;
`endif

    assign c0_pair   = CB_FIRST ? cb_pair : cr_pair;
    assign c1_pair   = CB_FIRST ? cr_pair : cb_pair;
    // A lone pixel at the end of an odd line has no partner to average with.
    assign c0_single = CB_FIRST ? cb0_q   : cr0_q;

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        load_p0   = 1'b0;
        load_pair = 1'b0;
        emit      = 1'b0;
        word_nxt  = word_q;
        case (state)
            ST_EVEN: begin
                if (accept) begin
                    load_p0   = 1'b1;
                    state_nxt = ST_ODD;
                end
            end
            ST_ODD: begin
                if (accept) begin
                    load_pair = 1'b1;
                    emit      = 1'b1;
                    word_nxt  = pack_word(c0_pair, y0_q);
                    state_nxt = ST_EMIT1;
                end else if (!per_frame_href) begin
                    // Line ended on an unpaired pixel: flush it so it is not lost.
                    emit      = 1'b1;
                    word_nxt  = pack_word(c0_single, y0_q);
                    state_nxt = ST_EVEN;
                end
            end
            ST_EMIT1: begin
                emit     = 1'b1;
                word_nxt = pack_word(c1_q, y1_q);
                // A pixel arriving now starts the next pair, keeping a
                // continuous clken stream at full rate.
                if (accept) begin
                    load_p0   = 1'b1;
                    state_nxt = ST_ODD;
                end else begin
                    state_nxt = ST_EVEN;
                end
            end
            default: state_nxt = ST_EVEN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EVEN;
            y0_q      <= '0;
            cb0_q     <= '0;
            cr0_q     <= '0;
            y1_q      <= '0;
            c1_q      <= '0;
            word_q    <= '0;
            clken_q   <= 1'b0;
            vsync_dly <= '0;
            href_dly  <= '0;
        end else begin
            state     <= state_nxt;
            word_q    <= word_nxt;
            clken_q   <= emit;
            vsync_dly <= {vsync_dly[SYNC_DLY-2:0], per_frame_vsync};
            href_dly  <= {href_dly[SYNC_DLY-2:0], per_frame_href};
            if (load_p0) begin
                y0_q  <= per_img_Y;
                cb0_q <= per_img_Cb;
                cr0_q <= per_img_Cr;
            end
            if (load_pair) begin
                y1_q <= per_img_Y;
                c1_q <= c1_pair;
            end
        end
    end

    assign post_frame_vsync = vsync_dly[SYNC_DLY-1];
    assign post_frame_href  = href_dly[SYNC_DLY-1];
    assign post_frame_clken = clken_q;
    assign post_img_YCbCr   = word_q;

endmodule

// File: tb/tb_image_ycbcr444_ycbcr422.sv
// ---------------------------------------------------------------------------
// tb_image_ycbcr444_ycbcr422
//  Drives two packers (CB_FIRST=1 and CB_FIRST=0) from one pixel stream.
//  The reference model collects pixels into pairs and pushes the expected
//  words, with the clock at which each must appear, into one queue per DUT;
//  a negedge monitor pops and compares every strobed word.
//  Follows the CHROMA_AVG_EN define of the build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_image_ycbcr444_ycbcr422;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b0, href = 1'b0, clken = 1'b0;
    logic [7:0] in_y = '0, in_cb = '0, in_cr = '0;

    logic        a_vs, a_hr, a_ce, b_vs, b_hr, b_ce;
    logic [15:0] a_img, b_img;

    always #5 clk = ~clk;

    image_ycbcr444_ycbcr422 #(.CB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
        .per_img_Y(in_y), .per_img_Cb(in_cb), .per_img_Cr(in_cr),
        .post_frame_vsync(a_vs), .post_frame_href(a_hr),
        .post_frame_clken(a_ce), .post_img_YCbCr(a_img));

    image_ycbcr444_ycbcr422 #(.CB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
        .per_img_Y(in_y), .per_img_Cb(in_cb), .per_img_Cr(in_cr),
        .post_frame_vsync(b_vs), .post_frame_href(b_hr),
        .post_frame_clken(b_ce), .post_img_YCbCr(b_img));

    typedef struct {
        logic [15:0] w;
        int          cyc;
    } exp_t;

    exp_t qa[$], qb[$];
    int   checks = 0, errors = 0;
    int   cyc = 0;
    int   strobes_a = 0;
    logic [15:0] last_a = '0, last_b = '0;

    // Model state: a pixel waiting for its partner.
    bit         pend = 1'b0;
    logic [7:0] p_y, p_cb, p_cr;
    logic       vs_lvl = 1'b0;
    logic [7:0] ly[$], lcb[$], lcr[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] pair_c(input int c0, input int c1);
`ifdef CHROMA_AVG_EN
        return 8'((c0 + c1 + 1) / 2);
`else
        return (c1 >= 0) ? 8'(c0) : 8'(c0);
`endif
    endfunction

    // One clock of stimulus; updates the pairing model for the coming edge.
    task automatic step(input logic vs, input logic hr, input logic ce,
                        input logic [7:0] py, input logic [7:0] pcb, input logic [7:0] pcr);
        logic [7:0] cbp, crp;
        @(posedge clk);
        #1;
        vsync = vs; href = hr; clken = ce;
        in_y = py; in_cb = pcb; in_cr = pcr;
        if (hr && ce) begin
            if (!pend) begin
                p_y = py; p_cb = pcb; p_cr = pcr;
                pend = 1'b1;
            end else begin
                cbp = pair_c(int'(p_cb), int'(pcb));
                crp = pair_c(int'(p_cr), int'(pcr));
                qa.push_back('{w: {cbp, p_y}, cyc: cyc + 1});
                qa.push_back('{w: {crp, py},  cyc: cyc + 2});
                qb.push_back('{w: {crp, p_y}, cyc: cyc + 1});
                qb.push_back('{w: {cbp, py},  cyc: cyc + 2});
                pend = 1'b0;
            end
        end else if (!hr && pend) begin
            qa.push_back('{w: {p_cb, p_y}, cyc: cyc + 1});
            qb.push_back('{w: {p_cr, p_y}, cyc: cyc + 1});
            pend = 1'b0;
        end
    endtask

    task automatic idle(input logic hr);
        step(vs_lvl, hr, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic add_px(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        ly.push_back(y); lcb.push_back(cb); lcr.push_back(cr);
    endtask

    task automatic rand_line(input int n);
        ly.delete(); lcb.delete(); lcr.delete();
        for (int i = 0; i < n; i++) add_px(8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    // mode 0: continuous clken; 1: every other clk; 2: random gaps.
    task automatic send_line(input int mode);
        for (int i = 0; i < ly.size(); i++) begin
            if (mode == 1 && i > 0) step(vs_lvl, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
            if (mode == 2) begin
                int gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++)
                    step(vs_lvl, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
            end
            step(vs_lvl, 1'b1, 1'b1, ly[i], lcb[i], lcr[i]);
        end
        for (int i = 0; i < 3; i++) idle(1'b0);
    endtask

    // Expected delayed syncs: inputs two edges ago, cleared by reset.
    logic [1:0] vs_h, hr_h;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_h <= '0;
            hr_h <= '0;
        end else begin
            vs_h <= {vs_h[0], vsync};
            hr_h <= {hr_h[0], href};
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("a_vsync_dly", a_vs, vs_h[1]);
            check("a_href_dly",  a_hr, hr_h[1]);
            check("b_href_dly",  b_hr, hr_h[1]);
            if (a_ce) begin
                strobes_a++;
                if (qa.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_extra_word: got 0x%0h expected no word (cycle %0d)", a_img, cyc);
                end else begin
                    e = qa.pop_front();
                    check("a_word", a_img, e.w);
                    check("a_word_cycle", cyc, e.cyc);
                    check("a_word_in_href", a_hr, 1);
                    last_a = e.w;
                end
            end else begin
                check("a_hold", a_img, last_a);
            end
            if (b_ce) begin
                if (qb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_extra_word: got 0x%0h expected no word (cycle %0d)", b_img, cyc);
                end else begin
                    e = qb.pop_front();
                    check("b_word", b_img, e.w);
                    check("b_word_cycle", cyc, e.cyc);
                    last_b = e.w;
                end
            end else begin
                check("b_hold", b_img, last_b);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int s0;
        #22;
        check("rst_a_img",   a_img, 0);
        check("rst_a_clken", a_ce,  0);
        check("rst_a_href",  a_hr,  0);
        check("rst_b_img",   b_img, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle(1'b0);

        // Test 1/2/6b: reference four pixels, continuous clken.
        ly.delete(); lcb.delete(); lcr.delete();
        add_px(8'd10, 8'd100, 8'd200);
        add_px(8'd20, 8'd110, 8'd210);
        add_px(8'd30, 8'd120, 8'd220);
        add_px(8'd40, 8'd130, 8'd230);
        send_line(0);

        // Test 3: odd line of three, then a line that must pair from its start.
        ly.delete(); lcb.delete(); lcr.delete();
        add_px(8'd1, 8'd11, 8'd21);
        add_px(8'd2, 8'd12, 8'd22);
        add_px(8'd3, 8'd13, 8'd23);
        send_line(0);
        rand_line(4);
        send_line(0);

        // Test 5: rounding corners.
        ly.delete(); lcb.delete(); lcr.delete();
        add_px(8'd50, 8'hFF, 8'h01);
        add_px(8'd60, 8'hFE, 8'h02);
        add_px(8'd70, 8'h01, 8'hFF);
        add_px(8'd80, 8'h02, 8'hFE);
        send_line(2);

        // Test 4: 640 pixels with clken every other clock.
        s0 = strobes_a;
        rand_line(640);
        send_line(1);
        idle(1'b0);
        check("strobes_640", strobes_a - s0, 640);

        // Test 6: reset after a pair was emitted and a new p0 is held.
        ly.delete(); lcb.delete(); lcr.delete();
        step(vs_lvl, 1'b1, 1'b1, 8'd90, 8'd91, 8'd92);
        step(vs_lvl, 1'b1, 1'b1, 8'd93, 8'd94, 8'd95);
        step(vs_lvl, 1'b1, 1'b1, 8'd96, 8'd97, 8'd98);
        repeat (3) step(vs_lvl, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_a_img",   a_img, 0);
        check("midrst_a_clken", a_ce,  0);
        check("midrst_a_href",  a_hr,  0);
        check("midrst_b_img",   b_img, 0);
        pend = 1'b0;
        last_a = '0;
        last_b = '0;
        href = 1'b0;
        clken = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) idle(1'b0);

        // Randomised frames: line lengths, clken patterns and vsync changes.
        for (int l = 0; l < 40; l++) begin
            if (l % 8 == 0) begin
                vs_lvl = ~vs_lvl;
                idle(1'b0);
            end
            rand_line($urandom_range(1, 33));
            send_line($urandom_range(0, 2));
        end

        repeat (5) idle(1'b0);
        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
